me_best_mv_select: RTL and testbench

- Sits directly downstream of the motion-estimation datapath and its controller. Consumes the stream of per-candidate SAD values for one 16x16 macroblock over a 48x48 search window.
- Tracks the minimum SAD and the candidate position that produced it.
- After the last candidate, emits the best motion vector and its SAD to the mode-decision / residual stage with a one-cycle done pulse.

---
 rtl/me_best_mv_select_if.sv | 43 ++++
 rtl/me_best_mv_select.sv | 148 ++++++++++++++
 tb/tb_me_best_mv_select.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/me_best_mv_select_if.sv
// ---------------------------------------------------------------------------
// me_best_mv_select_if
//   Bus between the motion-estimation datapath/controller (master) and the
//   best-motion-vector selector (slave).
//
// Handshake: sad_valid is a one-way valid with no ready. Whenever the
// selector is searching, it takes every cycle with sad_valid=1 as the next
// candidate in raster order. Outside a search, sad_valid is dropped. start is
// a one-cycle pulse. done is a one-cycle pulse, and mv_x/mv_y/min_sad are
// valid while it is high. They hold their values until the next done.
//
// Signals:
//   start      master->slave  begin (or restart) a macroblock search
//   sad_valid  master->slave  sad_in carries the next candidate's SAD
//   sad_in     master->slave  unsigned SAD of that candidate
//   busy       slave->master  search in progress
//   done       slave->master  result pulse
//   mv_x/mv_y  slave->master  signed best motion vector
//   min_sad    slave->master  SAD of the best candidate
// ---------------------------------------------------------------------------
interface me_best_mv_select_if #(
  parameter int SAD_W = 16,
  parameter int MV_W  = 6
);
  logic                    start;
  logic                    sad_valid;
  logic [SAD_W-1:0]        sad_in;
  logic                    busy;
  logic                    done;
  logic signed [MV_W-1:0]  mv_x;
  logic signed [MV_W-1:0]  mv_y;
  logic [SAD_W-1:0]        min_sad;

  modport master (
    output start, sad_valid, sad_in,
    input  busy, done, mv_x, mv_y, min_sad
  );

  modport slave (
    input  start, sad_valid, sad_in,
    output busy, done, mv_x, mv_y, min_sad
  );
endinterface

// File: rtl/me_best_mv_select.sv
// ---------------------------------------------------------------------------
// me_best_mv_select
//   Scans the per-candidate SAD stream of one macroblock search. The
//   candidates arrive in raster order over an N x N grid, where
//   N = SEARCH_DIM-MACRO_DIM+1. The block keeps the minimum SAD and the
//   position that produced it. After the last candidate it presents the best
//   motion vector and its SAD, together with a one-cycle done pulse.
//
// Optional build macro: ME_ZERO_MV_BIAS_EN
//   When it is defined, a SAD tie goes to the candidate that is closer to
//   MV (0,0) in L1 distance. When the distance is also equal, the earlier
//   candidate is kept. When it is undefined, ties keep the earliest
//   candidate.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active HIGH despite the name
//   bus        me_best_mv_select_if.slave (start/sad_valid/sad_in in;
//              busy/done/mv_x/mv_y/min_sad out)
//   dbg_state  current FSM state (0=IDLE, 1=SEARCH, 2=DONE)
// ---------------------------------------------------------------------------
module me_best_mv_select #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  parameter int MV_W       = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  me_best_mv_select_if.slave      bus,
  output logic [1:0]              dbg_state
);

  localparam int N    = SEARCH_DIM - MACRO_DIM + 1;
  localparam int CW   = $clog2(N);
  localparam int HALF = (N - 1) / 2;
  localparam logic [CW-1:0]   LAST_POS = CW'(N - 1);
  localparam logic [MV_W:0]   HALF_MV  = (MV_W+1)'(HALF);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]          cx, cy;
  logic [CW-1:0]          best_x, best_y;
  logic [SAD_W-1:0]       best_sad;
  logic signed [MV_W-1:0] mv_x_q, mv_y_q;
  logic [SAD_W-1:0]       min_sad_q;

  logic                   accept;
  logic                   last_pos;
  logic                   better;
  logic [SAD_W-1:0]       fin_sad;
  logic [CW-1:0]          fin_x, fin_y;
  logic [MV_W:0]          mvx_full, mvy_full;

  assign last_pos = (cx == LAST_POS) && (cy == LAST_POS);

`ifdef ME_ZERO_MV_BIAS_EN
  // L1 distance of a grid position from the zero-MV centre.
  function automatic logic [CW:0] dist(input logic [CW-1:0] p);
    if (p >= CW'(HALF)) dist = {1'b0, p - CW'(HALF)};
    else                dist = {1'b0, CW'(HALF) - p};
  endfunction

  logic [CW+1:0] cand_cost, best_cost;
  assign cand_cost = {1'b0, dist(cx)} + {1'b0, dist(cy)};
  assign best_cost = {1'b0, dist(best_x)} + {1'b0, dist(best_y)};
  assign better    = (bus.sad_in < best_sad) ||
                     ((bus.sad_in == best_sad) && (cand_cost < best_cost));
`else
  // Strict compare: on a tie the earlier (raster-order) candidate stays.
  assign better = (bus.sad_in < best_sad);
`endif

  // The best value after the current candidate has been compared. It is used
  // so that the last candidate takes part in the result published in DONE.
  assign fin_sad  = better ? bus.sad_in : best_sad;
  assign fin_x    = better ? cx : best_x;
  assign fin_y    = better ? cy : best_y;
  assign mvx_full = (MV_W+1)'(fin_x) - HALF_MV;
  assign mvy_full = (MV_W+1)'(fin_y) - HALF_MV;

  // Next state. start always wins: it restarts from SEARCH in any state.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nxt = SEARCH;
      SEARCH: begin
        if (bus.start) begin
          state_nxt = SEARCH;
        end else if (bus.sad_valid) begin
          accept = 1'b1;
          if (last_pos) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = bus.start ? SEARCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      best_x    <= '0;
      best_y    <= '0;
      best_sad  <= '0;
      mv_x_q    <= '0;
      mv_y_q    <= '0;
      min_sad_q <= '0;
    end else begin
      state <= state_nxt;
      if (bus.start) begin
        cx       <= '0;
        cy       <= '0;
        best_x   <= '0;
        best_y   <= '0;
        best_sad <= '1;
      end else if (accept) begin
        best_sad <= fin_sad;
        best_x   <= fin_x;
        best_y   <= fin_y;
        if (cx == LAST_POS) begin
          cx <= '0;
          cy <= last_pos ? '0 : cy + CW'(1);
        end else begin
          cx <= cx + CW'(1);
        end
        if (last_pos) begin
          mv_x_q    <= $signed(mvx_full[MV_W-1:0]);
          mv_y_q    <= $signed(mvy_full[MV_W-1:0]);
          min_sad_q <= fin_sad;
        end
      end
    end
  end

  assign bus.busy    = (state == SEARCH);
  assign bus.done    = (state == DONE);
  assign bus.mv_x    = mv_x_q;
  assign bus.mv_y    = mv_y_q;
  assign bus.min_sad = min_sad_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_me_best_mv_select.sv
module tb_me_best_mv_select;

  localparam int SAD_W = 16;
  localparam int MV_W  = 6;
  localparam int NC    = 1089;
  localparam int W     = 2*MV_W + SAD_W;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  me_best_mv_select_if #(.SAD_W(SAD_W), .MV_W(MV_W)) bus ();

  me_best_mv_select #(
    .MACRO_DIM(16), .SEARCH_DIM(48), .SAD_W(SAD_W), .MV_W(MV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int done_count;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pack(input int x, input int y, input int s);
    logic [W-1:0] r;
    r = {x[MV_W-1:0], y[MV_W-1:0], s[SAD_W-1:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (bus.done === 1'b1) begin
      done_count++;
      got = {bus.mv_x, bus.mv_y, bus.min_sad};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got=%0h expected=no_done", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL result got=%0h expected=%0h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    bus.start     = 1'b1;
    bus.sad_valid = 1'b0;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic send_sad(input logic [SAD_W-1:0] v, input bit gaps);
    if (gaps) begin
      bus.sad_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    bus.sad_valid = 1'b1;
    bus.sad_in    = v;
    step();
    bus.sad_valid = 1'b0;
  endtask

  // Full search: start, 1089 candidates, then the DONE cycle is checked.
  task automatic run_search(input string name, input int min_idx,
                            input logic [SAD_W-1:0] min_val,
                            input logic [SAD_W-1:0] other,
                            input bit gaps, input bit hold_after,
                            input int mvx, input int mvy, input int sad);
    int dc0;
    exp_q.push_back(pack(mvx, mvy, sad));
    send_start();
    dc0 = done_count;
    for (int i = 0; i < NC; i++) begin
      send_sad((i == min_idx) ? min_val : other, gaps);
      if (i == NC - 2) check({name, "_no_early_done"}, done_count, dc0);
    end
    check({name, "_done_latency"}, {31'd0, bus.done}, 32'd1);
    check({name, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    if (hold_after) begin
      bus.sad_valid = 1'b1;
      bus.sad_in    = '0;
      repeat (6) step();
      bus.sad_valid = 1'b0;
      check({name, "_idle_state"}, {30'd0, dbg_state}, 32'd0);
    end else begin
      step();
    end
    check({name, "_one_done"}, done_count, dc0 + 1);
    check({name, "_done_cleared"}, {31'd0, bus.done}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    checks        = 0;
    failures      = 0;
    done_count    = 0;
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in    = '0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    check("reset_busy",    {31'd0, bus.busy}, 32'd0);
    check("reset_done",    {31'd0, bus.done}, 32'd0);
    check("reset_mv",      {20'd0, bus.mv_x, bus.mv_y}, 32'd0);
    check("reset_min_sad", {16'd0, bus.min_sad}, 32'd0);
    check("reset_state",   {30'd0, dbg_state}, 32'd0);

    // A single minimum at index 600 (cx=6, cy=18).
    send_start();
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    exp_q.push_back(pack(-10, 2, 5));
    dc = done_count;
    for (int i = 0; i < NC; i++) send_sad((i == 600) ? 16'd5 : 16'd1000, 1'b0);
    check("t1_done_latency", {31'd0, bus.done}, 32'd1);
    check("t1_busy_low",     {31'd0, bus.busy}, 32'd0);
    step();
    check("t1_one_done", done_count, dc + 1);

    // All SADs equal.
`ifdef ME_ZERO_MV_BIAS_EN
    run_search("t2_all_equal", -1, 16'd300, 16'd300, 1'b0, 1'b0, 0, 0, 300);
`else
    run_search("t2_all_equal", -1, 16'd300, 16'd300, 1'b0, 1'b0, -16, -16, 300);
`endif

    // Minimum on the last candidate, with random valid gaps.
    run_search("t3_last", NC - 1, 16'd0, 16'd50, 1'b1, 1'b0, 16, 16, 0);

    // Abort after 400 candidates of a smaller SAD, then a clean full run.
    dc = done_count;
    send_start();
    for (int i = 0; i < 400; i++) send_sad(16'd3, 1'b0);
    check("t4_no_done_on_abort", done_count, dc);
    run_search("t4_restart", 0, 16'd7, 16'd100, 1'b0, 1'b0, -16, -16, 7);

    // Reset in the middle of a search.
    send_start();
    for (int i = 0; i < 500; i++) send_sad(16'd20, 1'b0);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    check("t5_busy",    {31'd0, bus.busy}, 32'd0);
    check("t5_done",    {31'd0, bus.done}, 32'd0);
    check("t5_mv",      {20'd0, bus.mv_x, bus.mv_y}, 32'd0);
    check("t5_min_sad", {16'd0, bus.min_sad}, 32'd0);
    dc = done_count;
    for (int i = 0; i < 1100; i++) send_sad(16'd1, 1'b0);
    step();
    check("t5_no_done_without_start", done_count, dc);

    // sad_valid held high in IDLE and DONE must not advance the counters.
    bus.sad_valid = 1'b1;
    bus.sad_in    = '0;
    repeat (20) step();
    bus.sad_valid = 1'b0;
    run_search("t6_centre", 544, 16'd9, 16'd200, 1'b0, 1'b1, 0, 0, 9);
    run_search("t6_next",   100, 16'd4, 16'd200, 1'b0, 1'b0, -15, -13, 4);

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
